// File: rtl/spi_defines_pkg.sv
// Shared types for the SPI transmit engine: FSM state encoding, SPI mode pair
// and the bit-counter sizing helper.
package spi_defines_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SHIFT,
    ST_COMPLETE,
    ST_GAP
  } spi_tx_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // Wide enough to hold DATA_WIDTH itself, not just DATA_WIDTH-1.
  function automatic int bit_cnt_width(input int data_width);
    return $clog2(data_width + 1);
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SPI clock generator: divides clk into sclk half-periods of CLK_DIV cycles
// while enabled, and flags the cycle on which each sclk edge is launched.
module spi_clk_gen #(
  parameter int CLK_DIV = 2,
  parameter bit CPOL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic sclk,
  output logic leading_edge,
  output logic trailing_edge
);

  localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIVW-1:0] div;
  logic            wrap;

  assign wrap          = enable && (div == DIVW'(CLK_DIV - 1));
  // An edge leaving the idle level is a leading edge; returning to it is trailing.
  assign leading_edge  = wrap && (sclk == CPOL);
  assign trailing_edge = wrap && (sclk != CPOL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div  <= '0;
      sclk <= CPOL;
    end else if (!enable) begin
      div  <= '0;
      sclk <= CPOL;
    end else if (wrap) begin
      div  <= '0;
      sclk <= ~sclk;
    end else begin
      div  <= div + 1'b1;
    end
  end

endmodule

// File: rtl/spi_tx_engine.sv
// SPI master transmit engine: pops FIFO words and shifts them out framed by cs_n.
// Optional receive path (miso, rx_data, rx_valid) built when SPI_TX_ENGINE_RX_EN is defined.
module spi_tx_engine
  import spi_defines_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2,
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0,
  parameter bit LSB_FIRST  = 1'b0,
  parameter int CS_GAP     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_en,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  cs_n,
  output logic                  busy,
`ifdef SPI_TX_ENGINE_RX_EN
  input  logic                  miso,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
`endif
  output logic                  done
);

  localparam int        CW   = bit_cnt_width(DATA_WIDTH);
  localparam int        GW   = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam spi_mode_t MODE = '{cpol: CPOL, cpha: CPHA};

  spi_tx_state_t         state, next_state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CW-1:0]         bit_cnt;
  logic [GW-1:0]         gap_cnt;
  logic                  leading_edge, trailing_edge;
  logic                  sample_edge, shift_edge, last_edge;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] d);
    return LSB_FIRST ? d[0] : d[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] d);
    return LSB_FIRST ? (d >> 1) : (d << 1);
  endfunction

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV),
    .CPOL    (CPOL)
  ) u_clk_gen (
    .clk           (clk),
    .rst           (rst),
    .enable        (state == ST_SHIFT),
    .sclk          (sclk),
    .leading_edge  (leading_edge),
    .trailing_edge (trailing_edge)
  );

  // With CPHA=0 the first bit is preloaded in LOAD, so the closing trailing edge has nothing left to drive.
  assign sample_edge = MODE.cpha ? trailing_edge : leading_edge;
  assign shift_edge  = MODE.cpha ? leading_edge : (trailing_edge && (bit_cnt != '0));
  assign last_edge   = trailing_edge && (MODE.cpha ? (bit_cnt == CW'(1)) : (bit_cnt == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:     if (!empty) next_state = ST_FETCH;
      ST_FETCH:    next_state = ST_LOAD;
      ST_LOAD:     next_state = ST_SHIFT;
      ST_SHIFT:    if (last_edge) next_state = ST_COMPLETE;
      ST_COMPLETE: next_state = (CS_GAP > 0) ? ST_GAP : ST_IDLE;
      ST_GAP:      if (int'(gap_cnt) == CS_GAP - 1) next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  // Strobes are registered from next_state so they are visible during the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_en   <= 1'b0;
      mosi      <= 1'b0;
      cs_n      <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      read_en <= (next_state == ST_FETCH);
      busy    <= (next_state != ST_IDLE);
      done    <= (next_state == ST_COMPLETE);
      if (next_state == ST_LOAD)   cs_n <= 1'b0;
      else if (state == ST_COMPLETE) cs_n <= 1'b1;
      case (state)
        ST_LOAD: begin
          bit_cnt <= CW'(DATA_WIDTH);
          if (!MODE.cpha) begin
            mosi      <= first_bit(read_data);
            shift_reg <= advance(read_data);
          end else begin
            shift_reg <= read_data;
          end
        end
        ST_SHIFT: begin
          if (sample_edge) bit_cnt <= bit_cnt - 1'b1;
          if (shift_edge) begin
            mosi      <= first_bit(shift_reg);
            shift_reg <= advance(shift_reg);
          end
        end
        ST_COMPLETE: gap_cnt <= '0;
        ST_GAP:      gap_cnt <= gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef SPI_TX_ENGINE_RX_EN
  logic [DATA_WIDTH-1:0] rx_shift, rx_next;

  // The final CPHA=1 sample lands on the same cycle COMPLETE is entered, so publish the post-sample value.
  always_comb begin
    rx_next = rx_shift;
    if (state == ST_SHIFT && sample_edge)
      rx_next = LSB_FIRST ? {miso, rx_shift[DATA_WIDTH-1:1]} : {rx_shift[DATA_WIDTH-2:0], miso};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_shift <= rx_next;
      rx_valid <= (next_state == ST_COMPLETE);
      if (next_state == ST_COMPLETE) rx_data <= rx_next;
    end
  end
`endif

endmodule

// File: tb/tb_spi_tx_engine.sv
// Bench for spi_tx_engine: two instances (mode 0 MSB-first, mode 3 LSB-first) fed by
// queue-model FIFOs, checked by an SPI-slave-style monitor that decodes the pins.
module tb_spi_tx_engine;

  localparam int DW   = 8;
  localparam int CD0  = 2;
  localparam int CD1  = 1;
  localparam int GAP0 = 2;
  localparam int GAP1 = 0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          empty_a   [2];
  logic [DW-1:0] rdat      [2];
  logic          read_en_a [2];
  logic          sclk_a    [2];
  logic          mosi_a    [2];
  logic          cs_n_a    [2];
  logic          busy_a    [2];
  logic          done_a    [2];
`ifdef SPI_TX_ENGINE_RX_EN
  logic [DW-1:0] rxd_a     [2];
  logic          rxv_a     [2];
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [DW-1:0] fq [2][$];
  int            npush [2], nfetch [2], ndone [2], lost [2];
  int            edges [2], nb [2], rd_cyc [2], done_cyc [2];
  logic          inflight [2], b2b [2], psclk [2], pcs [2];
  logic [DW-1:0] cur [2], mon_word [2];

  always #5 clk = ~clk;

  function automatic int cd(input int k);    return (k == 0) ? CD0 : CD1;   endfunction
  function automatic int gp(input int k);    return (k == 0) ? GAP0 : GAP1; endfunction
  function automatic logic cpol(input int k); return (k != 0); endfunction
  function automatic logic cpha(input int k); return (k != 0); endfunction
  function automatic logic lsbf(input int k); return (k != 0); endfunction

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  spi_tx_engine #(.DATA_WIDTH(DW), .CLK_DIV(CD0), .CPOL(1'b0), .CPHA(1'b0),
                  .LSB_FIRST(1'b0), .CS_GAP(GAP0)) u_mode0 (
    .clk(clk), .rst(rst), .empty(empty_a[0]), .read_data(rdat[0]),
    .read_en(read_en_a[0]), .sclk(sclk_a[0]), .mosi(mosi_a[0]), .cs_n(cs_n_a[0]),
    .busy(busy_a[0]),
`ifdef SPI_TX_ENGINE_RX_EN
    .miso(mosi_a[0]), .rx_data(rxd_a[0]), .rx_valid(rxv_a[0]),
`endif
    .done(done_a[0]));

  spi_tx_engine #(.DATA_WIDTH(DW), .CLK_DIV(CD1), .CPOL(1'b1), .CPHA(1'b1),
                  .LSB_FIRST(1'b1), .CS_GAP(GAP1)) u_mode3 (
    .clk(clk), .rst(rst), .empty(empty_a[1]), .read_data(rdat[1]),
    .read_en(read_en_a[1]), .sclk(sclk_a[1]), .mosi(mosi_a[1]), .cs_n(cs_n_a[1]),
    .busy(busy_a[1]),
`ifdef SPI_TX_ENGINE_RX_EN
    .miso(mosi_a[1]), .rx_data(rxd_a[1]), .rx_valid(rxv_a[1]),
`endif
    .done(done_a[1]));

  // FIFO model plus pin-level monitor; everything is sampled and driven on the falling edge.
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        if (inflight[k]) lost[k]++;
        inflight[k] = 1'b0;
        b2b[k]      = 1'b0;
        edges[k]    = 0;
        nb[k]       = 0;
        psclk[k]    = cpol(k);
        pcs[k]      = 1'b1;
      end else begin
        if (read_en_a[k]) begin
          check("rd_nonempty", int'(fq[k].size() > 0), 1);
          check("busy_fetch", busy_a[k], 1);
          if (b2b[k]) check("frame_gap", cyc - done_cyc[k], gp(k) + 2);
          b2b[k] = 1'b0;
          if (fq[k].size() > 0) begin
            cur[k]      = fq[k].pop_front();
            rdat[k]     = cur[k];
            inflight[k] = 1'b1;
          end
          rd_cyc[k] = cyc;
          nfetch[k]++;
        end
        if (cs_n_a[k] != pcs[k]) begin
          if (!cs_n_a[k]) check("cs_fall", cyc - rd_cyc[k], 1);
          else            check("cs_rise", cyc - done_cyc[k], 1);
        end
        if (sclk_a[k] != psclk[k]) begin
          edges[k]++;
          check("sclk_in_frame", cs_n_a[k], 0);
          // Sampling edge: leading for CPHA=0, trailing for CPHA=1.
          if (((sclk_a[k] != cpol(k)) != cpha(k)) && nb[k] < DW) begin
            mon_word[k][lsbf(k) ? nb[k] : DW - 1 - nb[k]] = mosi_a[k];
            nb[k]++;
          end
        end
        if (done_a[k]) begin
          check("done_inflight", inflight[k], 1);
          check("latency", cyc - rd_cyc[k], 2 + 2 * DW * cd(k));
          check("edge_count", edges[k], 2 * DW);
          check("word", mon_word[k], cur[k]);
          check("sclk_rest", sclk_a[k], cpol(k));
          check("cs_complete", cs_n_a[k], 0);
          check("busy_complete", busy_a[k], 1);
`ifdef SPI_TX_ENGINE_RX_EN
          check("rx_valid", rxv_a[k], 1);
          check("rx_data", rxd_a[k], cur[k]);
`endif
          done_cyc[k] = cyc;
          b2b[k]      = (fq[k].size() > 0);
          inflight[k] = 1'b0;
          edges[k]    = 0;
          nb[k]       = 0;
          ndone[k]++;
        end
`ifdef SPI_TX_ENGINE_RX_EN
        if (rxv_a[k] && !done_a[k]) check("rx_valid_align", 1, 0);
`endif
        psclk[k] = sclk_a[k];
        pcs[k]   = cs_n_a[k];
      end
      empty_a[k] = (fq[k].size() == 0);
    end
  end

  task automatic push(input int k, input logic [DW-1:0] w);
    fq[k].push_back(w);
    npush[k]++;
  endtask

  task automatic wait_idle();
    int quiet = 0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      if (fq[0].size() == 0 && fq[1].size() == 0 && !busy_a[0] && !busy_a[1]) quiet++;
      else quiet = 0;
      if (quiet >= 3) return;
    end
    check("idle_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      check({tag, "_sclk"}, sclk_a[k], cpol(k));
      check({tag, "_cs_n"}, cs_n_a[k], 1);
      check({tag, "_busy"}, busy_a[k], 0);
      check({tag, "_done"}, done_a[k], 0);
      check({tag, "_read_en"}, read_en_a[k], 0);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      empty_a[k] = 1'b1; rdat[k] = '0;
      npush[k] = 0; nfetch[k] = 0; ndone[k] = 0; lost[k] = 0;
      edges[k] = 0; nb[k] = 0; rd_cyc[k] = 0; done_cyc[k] = 0;
      inflight[k] = 1'b0; b2b[k] = 1'b0; psclk[k] = cpol(k); pcs[k] = 1'b1;
      cur[k] = '0; mon_word[k] = '0;
    end
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("rst");
    check("rst_mosi0", mosi_a[0], 0);
    check("rst_mosi1", mosi_a[1], 0);
`ifdef SPI_TX_ENGINE_RX_EN
    check("rst_rx_data", rxd_a[0], 0);
`endif
    rst = 1'b0;

    // Single words: 0xA5 on mode 0, 0x81 on mode 3 LSB-first.
    push(0, 8'hA5);
    push(1, 8'h81);
    wait_idle();

    // Back-to-back frames; the second must wait out COMPLETE and the CS gap.
    push(0, 8'h3C); push(0, 8'hC3);
    push(1, 8'h5A); push(1, 8'hA5);
    wait_idle();

    for (int it = 0; it < 25; it++) begin
      int k = int'($urandom_range(0, 1));
      int n = int'($urandom_range(1, 3));
      for (int j = 0; j < n; j++) push(k, DW'($urandom));
      if ($urandom_range(0, 1) == 1) push(1 - k, DW'($urandom));
      if ($urandom_range(0, 2) == 0) wait_idle();
      else repeat ($urandom_range(0, 60)) @(posedge clk);
    end
    wait_idle();

    // Abort a mode-0 frame after its 5th sclk edge.
    push(0, 8'hE7);
    begin
      int hit = 0;
      for (int i = 0; i < 500 && hit == 0; i++) begin
        @(posedge clk);
        if (edges[0] >= 5) hit = 1;
      end
      check("reset_trigger", hit, 1);
    end
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    @(posedge clk);
    #2 rst = 1'b0;
    push(0, 8'h5A);
    push(1, 8'h5A);
    wait_idle();

    for (int k = 0; k < 2; k++) begin
      check("fetch_count", nfetch[k], npush[k]);
      check("done_count", ndone[k] + lost[k], nfetch[k]);
    end
    check("lost_words", lost[0] + lost[1], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
